// File: rtl/open_drain_loopback_tester.sv
// Open-drain loopback tester: each pin takes a turn pulsing a shared
// pulled-up bus while the others count the edges they see.
module open_drain_loopback_tester #(
  parameter int CHANNELS      = 2,
  parameter int TICK_INTERVAL = 27000000,
  parameter int PULSE_COUNT   = 5
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  inout  wire  [CHANNELS-1:0] pin_io,
  output logic [CHANNELS-1:0] led_recv_o,
  output logic                busy_o,
  output logic                pass_o,
  output logic                fail_o,
  output logic [2:0]          fail_chan_o
);

  localparam int TW = $clog2(TICK_INTERVAL);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_INTERVAL - 1);
  localparam logic [TW-1:0] HALF      = TW'(TICK_INTERVAL / 2);
  localparam logic [TW-1:0] GUARD_LAST = TW'(3);
  localparam logic [31:0]   CHK_FROM  = 32'(TICK_INTERVAL / 2 + 3);
  localparam logic [3:0]    PULSE_LAST = 4'(PULSE_COUNT - 1);
  localparam logic [3:0]    PULSES    = 4'(PULSE_COUNT);
  localparam logic [2:0]    T_LAST    = 3'(CHANNELS - 1);

  typedef enum logic [2:0] {
    IDLE, SETTLE, TALK, GUARD, CHECK, DONE
  } state_t;

  state_t state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0]    pulse_q, pulse_d;
  logic [2:0]    talker_q, talker_d;
  logic          rb_q, rb_d;
  logic          pass_q, pass_d;
  logic          fail_q, fail_d;
  logic [2:0]    chan_q, chan_d;
  logic          clr_cnt;
  logic          lis_err;
  logic [2:0]    lis_idx;

  logic [CHANNELS-1:0] drive_low;
  logic [CHANNELS-1:0] s1_q, s2_q, sp_q;
  logic [CHANNELS-1:0] rise;
  logic [3:0]          cnt_q [CHANNELS];

  // Gated by rst_ni so a reset releases the bus without a clock edge.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_pin
    assign pin_io[i] = (drive_low[i] && rst_ni) ? 1'b0 : 1'bz;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= '1;
      s2_q <= '1;
      sp_q <= '1;
    end else begin
      s1_q <= pin_io;
      s2_q <= s1_q;
      sp_q <= s2_q;
    end
  end

  assign rise       = s2_q & ~sp_q;
  assign led_recv_o = s2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (clr_cnt) cnt_q[i] <= '0;
        else if (rise[i] && cnt_q[i] != 4'hF)
          cnt_q[i] <= cnt_q[i] + 4'd1;
      end
    end
  end

  // Descending scan so the lowest failing listener wins.
  always_comb begin
    lis_err = 1'b0;
    lis_idx = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (talker_q != 3'(i) && cnt_q[i] != PULSES) begin
        lis_err = 1'b1;
        lis_idx = 3'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    pulse_d   = pulse_q;
    talker_d  = talker_q;
    rb_d      = rb_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    chan_d    = chan_q;
    clr_cnt   = 1'b0;
    drive_low = '0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d  = SETTLE;
          tick_d   = '0;
          talker_d = '0;
          rb_d     = 1'b0;
          pass_d   = 1'b0;
          fail_d   = 1'b0;
          chan_d   = '0;
          clr_cnt  = 1'b1;
        end
      end
      SETTLE: begin
        if (tick_q == TICK_LAST) begin
          state_d = TALK;
          tick_d  = '0;
          pulse_d = '0;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      TALK: begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (talker_q == 3'(i) && tick_q >= HALF) begin
            drive_low[i] = 1'b1;
            if (32'(tick_q) >= CHK_FROM && s2_q[i]) rb_d = 1'b1;
          end
        end
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          pulse_d = pulse_q + 4'd1;
          if (pulse_q == PULSE_LAST) state_d = GUARD;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      GUARD: begin
        if (tick_q == GUARD_LAST) begin
          state_d = CHECK;
          tick_d  = '0;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      CHECK: begin
        if (rb_q || lis_err) begin
          state_d = DONE;
          fail_d  = 1'b1;
          chan_d  = rb_q ? talker_q : lis_idx;
        end else if (talker_q == T_LAST) begin
          state_d = DONE;
          pass_d  = 1'b1;
        end else begin
          state_d  = SETTLE;
          talker_d = talker_q + 3'd1;
          tick_d   = '0;
          rb_d     = 1'b0;
          clr_cnt  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      pulse_q  <= '0;
      talker_q <= '0;
      rb_q     <= 1'b0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
      chan_q   <= '0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      pulse_q  <= pulse_d;
      talker_q <= talker_d;
      rb_q     <= rb_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      chan_q   <= chan_d;
    end
  end

  assign busy_o      = !(state_q == IDLE || state_q == DONE);
  assign pass_o      = pass_q;
  assign fail_o      = fail_q;
  assign fail_chan_o = chan_q;

endmodule
